ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite slave memory with a programmable wait-state count and a two-cycle ERROR response. It consumes the AHB-Lite bus signal set (HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, HSEL) and produces the slave-side responses (HREADYOUT, HRESP, HRDATA). It is the downstream target that the bus interface/wrapper connects to in simulation and in small SoC builds.

Parameters:
MEM_WORDS, 1024, number of 32-bit words; valid byte addresses are 0 .. MEM_WORDS*4-1.
WAIT_STATES, 1, HREADYOUT-low cycles inserted per OKAY data phase; range 0..15.

Ports:
HCLK  in  1  bus clock, rising edge.
HRESET  in  1  asynchronous, active-high reset.
HSEL  in  1  slave select.
HADDR  in  32  byte address.
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HWRITE  in  1  1=write.
HSIZE  in  3  0=byte, 1=half, 2=word; larger values are errors.
HBURST  in  3  ignored; no functional effect.
HPROT  in  4  ignored.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  system ready; an address phase is accepted only when it is high.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0=OKAY, 1=ERROR.
HRDATA  out  32  read data.

Behaviour:
- Reset (HRESET=1, asynchronous): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0.
  - Pending data phase is dropped; a pending write is not committed.
  - Memory array is not cleared.
- Accept: at a rising HCLK with HSEL & HREADY & HTRANS[1]=1, latch HADDR, HSIZE and HWRITE into data-phase registers.
- IDLE/BUSY transfers, or HSEL=0: no latch; the slave stays in or returns to IDLE (zero-wait OKAY).
- Error check at accept. An access is an error if any of these holds:
  - HADDR >= MEM_WORDS*4;
  - HSIZE > 2;
  - half access with HADDR[0]=1;
  - word access with HADDR[1:0]!=0.
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0. On accept:
    - error -> ERR1;
    - else WAIT_STATES=0 -> DATA;
    - else WAIT, with cnt=WAIT_STATES.
  - WAIT: HREADYOUT=0, HRESP=0. cnt decrements each cycle; when cnt==1, go to DATA. This gives exactly WAIT_STATES low cycles.
  - DATA: HREADYOUT=1, HRESP=0.
    - At the closing edge, a write commits the HWDATA byte lanes selected by the latched HADDR[1:0] and HSIZE.
    - In the same edge, a new accept is evaluated (pipelined), with the same transitions as from IDLE; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept is evaluated as in DATA; otherwise go to IDLE. Errored writes never modify memory.
- Reads:
  - HRDATA = mem[latched word address] (combinational array read) while in WAIT or DATA of a read; 0 otherwise.
  - Byte/half reads return the full word; the master selects lanes.
- Write-then-read to the same address back-to-back: the read observes the new data, because the write commits at the edge that starts the read data phase.
- Byte-lane mapping: byte n = HWDATA[8n+7:8n] for address offset n, little-endian. Half at offset 2 uses lanes 3:2.
- Latency:
  - OKAY transfer: 1 + WAIT_STATES data-phase cycles.
  - ERROR transfer: 2 cycles.

Decomposition:
- Package ahb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE constants (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
  - HRESP_OKAY/HRESP_ERROR;
  - slave state enum (S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2).
- Sub-module ahb_byte_strobe: from addr[1:0] and size, produces the 4-bit lane strobe plus a misaligned flag. It is combinational and shared with future slaves.

Test Plan:
- Reset: assert HRESET for 3 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
- WAIT_STATES=2: word write 0xDEADBEEF to 0x10, then word read of 0x10 -> each data phase shows exactly 2 HREADYOUT-low cycles; read HRDATA=0xDEADBEEF when HREADYOUT=1.
- Byte write: word 0x11223344 at 0x20, then byte write to 0x21 with HWDATA=0x0000AA00 -> word read of 0x20 returns 0x1122AA44.
- Errors: write to 0x1000 (MEM_WORDS=1024), and word write to 0x22 -> each gives HREADYOUT/HRESP = 0/1 then 1/1; memory unchanged on readback.
- WAIT_STATES=0: NONSEQ write 0x5 to 0x40 immediately followed by NONSEQ read of 0x40 -> no low HREADYOUT cycles; read returns 0x5.
- Async reset mid-WAIT during a write of 0xCAFE to 0x30 -> HREADYOUT=1 in the same cycle, state IDLE; readback of 0x30 returns the old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave's state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slv_state_t;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite master/slave signal bundle.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane strobe and alignment check for an AHB access.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [1:0] addr_i,
    input  logic [2:0] size_i,
    output logic [3:0] strobe_o,
    output logic       misaligned_o
);

    always_comb begin
        strobe_o     = 4'b0000;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_BYTE: strobe_o = 4'b0001 << addr_i;
            SIZE_HALF: begin
                strobe_o     = addr_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_i[0];
            end
            SIZE_WORD: begin
                strobe_o     = 4'b1111;
                misaligned_o = (addr_i != 2'b00);
            end
            // Oversized transfers are rejected by the slave; no lanes enabled.
            default: strobe_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and a two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_sram_slave_if.slave ahb
);

    localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MemBytes = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    slv_state_t    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [3:0]    strobe_q;
    logic [31:0]   mem_q [MEM_WORDS];

    logic          accept;
    logic          latch;
    logic          acc_err;
    logic          misaligned;
    logic [3:0]    strobe;
    logic [AW-1:0] word_addr;
    logic          unused_ok;

    ahb_byte_strobe u_strobe (
        .addr_i       (ahb.HADDR[1:0]),
        .size_i       (ahb.HSIZE),
        .strobe_o     (strobe),
        .misaligned_o (misaligned)
    );

    assign accept    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign acc_err   = ({1'b0, ahb.HADDR} >= MemBytes) | (ahb.HSIZE > SIZE_WORD) | misaligned;
    assign word_addr = ahb.HADDR[AW+1:2];
    assign unused_ok = ^{ahb.HBURST, ahb.HPROT, ahb.HTRANS[0]};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q   <= word_addr;
                write_q  <= ahb.HWRITE;
                strobe_q <= strobe;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        unique case (state_q)
            // States that end a data phase may accept the next address phase.
            S_IDLE, S_DATA, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    latch = 1'b1;
                    if (acc_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WaitInit;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DATA;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = HRESP_OKAY;
        ahb.HRDATA    = '0;
        case (state_q)
            S_WAIT: ahb.HREADYOUT = 1'b0;
            S_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = HRESP_ERROR;
            end
            S_ERR2:  ahb.HRESP = HRESP_ERROR;
            default: ahb.HREADYOUT = 1'b1;
        endcase
        if ((state_q == S_WAIT || state_q == S_DATA) && !write_q) begin
            ahb.HRDATA = mem_q[addr_q];
        end
    end

    // Write commits at the edge closing DATA so a pipelined read sees it.
    always_ff @(posedge HCLK) begin
        if (state_q == S_DATA && write_q) begin
            for (int n = 0; n < 4; n++) begin
                if (strobe_q[n]) mem_q[addr_q][8*n +: 8] <= ahb.HWDATA[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (2 and 0 wait states) against a byte-level memory model.
module tb_ahb_sram_slave;

    logic HCLK;
    logic HRESET;

    ahb_sram_slave_if bus2 ();
    ahb_sram_slave_if bus0 ();

    bit          use0;
    logic        t_sel;
    logic [1:0]  t_trans;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_write;
    logic [2:0]  t_size;

    int total;
    int bad;

    logic [31:0] mdl [2][1024];

    assign bus2.HSEL   = t_sel & ~use0;
    assign bus0.HSEL   = t_sel & use0;
    assign bus2.HADDR  = t_addr;
    assign bus0.HADDR  = t_addr;
    assign bus2.HTRANS = t_trans;
    assign bus0.HTRANS = t_trans;
    assign bus2.HWRITE = t_write;
    assign bus0.HWRITE = t_write;
    assign bus2.HSIZE  = t_size;
    assign bus0.HSIZE  = t_size;
    assign bus2.HWDATA = t_wdata;
    assign bus0.HWDATA = t_wdata;
    assign bus2.HBURST = 3'b000;
    assign bus0.HBURST = 3'b000;
    assign bus2.HPROT  = 4'b0011;
    assign bus0.HPROT  = 4'b0011;
    assign bus2.HREADY = bus2.HREADYOUT;
    assign bus0.HREADY = bus0.HREADYOUT;

    wire        o_ready = use0 ? bus0.HREADYOUT : bus2.HREADYOUT;
    wire        o_resp  = use0 ? bus0.HRESP : bus2.HRESP;
    wire [31:0] o_rdata = use0 ? bus0.HRDATA : bus2.HRDATA;

    ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(2)) u_dut2 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .ahb    (bus2.slave)
    );

    ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .ahb    (bus0.slave)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
        if (a >= 32'd4096) return 1'b1;
        if (s > 3'd2) return 1'b1;
        return (a % (32'd1 << s)) != 32'd0;
    endfunction

    // One non-pipelined transfer; reports data-phase shape and read data.
    task automatic xfer(input bit d0, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int lows,
                        output logic resp_first, output logic resp_last, output bit timeout);
        bit first;
        bit done;
        use0    = d0;
        t_sel   = 1'b1;
        t_trans = 2'b10;
        t_addr  = a;
        t_write = wr;
        t_size  = sz;
        @(posedge HCLK);
        #1;
        t_sel      = 1'b0;
        t_trans    = 2'b00;
        t_wdata    = wd;
        lows       = 0;
        first      = 1'b1;
        done       = 1'b0;
        rd         = '0;
        resp_first = 1'b0;
        resp_last  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge HCLK);
            if (first) resp_first = o_resp;
            first = 1'b0;
            if (o_ready) begin
                rd        = o_rdata;
                resp_last = o_resp;
                done      = 1'b1;
            end else begin
                lows++;
            end
        end
        timeout = !done;
        @(posedge HCLK);
        #1;
    endtask

    // Transfer plus checks against the reference model.
    task automatic access(input string tag, input bit d0, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd, output logic [31:0] rd);
        int   lows;
        logic rf;
        logic rl;
        bit   to;
        int   ws;
        bit   e;
        int   off;
        int   len;
        xfer(d0, wr, a, sz, wd, rd, lows, rf, rl, to);
        ws = d0 ? 0 : 2;
        e  = model_err(a, sz);
        chk({tag, "_timeout"}, 64'(to), 64'd0);
        if (e) begin
            chk({tag, "_err_shape"}, {lows, rf, rl}, {32'd1, 1'b1, 1'b1});
        end else begin
            chk({tag, "_ok_shape"}, {lows, rf, rl}, {32'(ws), 1'b0, 1'b0});
            if (wr) begin
                off = int'(a % 32'd4);
                len = 1 << sz;
                for (int n = 0; n < 4; n++) begin
                    if (n >= off && n < off + len) mdl[d0][a[11:2]][8*n +: 8] = wd[8*n +: 8];
                end
            end else begin
                chk({tag, "_rdata"}, 64'(rd), 64'(mdl[d0][a[11:2]]));
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  sz;
        bit          d0;
        int          k;

        total   = 0;
        bad     = 0;
        use0    = 1'b0;
        t_sel   = 1'b0;
        t_trans = 2'b00;
        t_addr  = '0;
        t_wdata = '0;
        t_write = 1'b0;
        t_size  = 3'd0;
        HRESET  = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("rst_dut2", {bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA}, {1'b1, 1'b0, 32'h0});
            chk("rst_dut0", {bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA}, {1'b1, 1'b0, 32'h0});
        end
        #2 HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        access("wr10", 1'b0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd);
        access("rd10", 1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd);
        chk("rd10_const", 64'(rd), 64'hDEADBEEF);

        access("wr20", 1'b0, 1'b1, 32'h20, 3'd2, 32'h11223344, rd);
        access("wrb21", 1'b0, 1'b1, 32'h21, 3'd0, 32'h0000AA00, rd);
        access("rd20", 1'b0, 1'b0, 32'h20, 3'd2, 32'h0, rd);
        chk("rd20_const", 64'(rd), 64'h1122AA44);

        access("err_oor", 1'b0, 1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF, rd);
        access("err_mis", 1'b0, 1'b1, 32'h22, 3'd2, 32'hFFFFFFFF, rd);
        access("rd20_after_err", 1'b0, 1'b0, 32'h20, 3'd2, 32'h0, rd);
        chk("rd20_after_err_const", 64'(rd), 64'h1122AA44);

        // Back-to-back NONSEQ write then read on the zero-wait slave.
        use0    = 1'b1;
        t_sel   = 1'b1;
        t_trans = 2'b10;
        t_addr  = 32'h40;
        t_write = 1'b1;
        t_size  = 3'd2;
        @(posedge HCLK);
        #1;
        t_wdata = 32'h5;
        t_write = 1'b0;
        @(negedge HCLK);
        chk("pipe_wr_ready", 64'({o_ready, o_resp}), 64'b10);
        @(posedge HCLK);
        #1;
        t_sel   = 1'b0;
        t_trans = 2'b00;
        @(negedge HCLK);
        chk("pipe_rd_ready", 64'({o_ready, o_resp}), 64'b10);
        chk("pipe_rd_data", 64'(o_rdata), 64'h5);
        @(posedge HCLK);
        #1;
        mdl[1][16] = 32'h5;

        // Reset in the middle of a waited write must drop it.
        access("wr30", 1'b0, 1'b1, 32'h30, 3'd2, 32'h12345678, rd);
        use0    = 1'b0;
        t_sel   = 1'b1;
        t_trans = 2'b10;
        t_addr  = 32'h30;
        t_write = 1'b1;
        t_size  = 3'd2;
        @(posedge HCLK);
        #1;
        t_sel   = 1'b0;
        t_trans = 2'b00;
        t_wdata = 32'h0000CAFE;
        @(negedge HCLK);
        chk("arst_wait_low", 64'(o_ready), 64'd0);
        #2 HRESET = 1'b1;
        #1;
        chk("arst_immediate", 64'({o_ready, o_resp}), 64'b10);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        access("rd30", 1'b0, 1'b0, 32'h30, 3'd2, 32'h0, rd);
        chk("rd30_const", 64'(rd), 64'h12345678);

        // Randomized traffic over a prefilled window of both slaves.
        for (int i = 0; i < 16; i++) begin
            access("fill2", 1'b0, 1'b1, 32'h100 + 32'(4 * i), 3'd2, $urandom, rd);
            access("fill0", 1'b1, 1'b1, 32'h100 + 32'(4 * i), 3'd2, $urandom, rd);
        end
        for (int i = 0; i < 80; i++) begin
            d0 = 1'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 9));
            sz = 3'($urandom_range(0, 2));
            a  = 32'h100 + 32'(4 * $urandom_range(0, 15));
            if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
            if (sz == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
            if (k == 0) begin
                case ($urandom_range(0, 2))
                    0: begin a = 32'h1000 + 32'(4 * $urandom_range(0, 255)); sz = 3'd2; end
                    1: begin a = a + 32'($urandom_range(1, 3)); sz = 3'd2; end
                    default: sz = 3'd3;
                endcase
                access("rnd_err", d0, 1'($urandom_range(0, 1)), a, sz, $urandom, rd);
            end else if (k < 5) begin
                access("rnd_wr", d0, 1'b1, a, sz, $urandom, rd);
            end else begin
                access("rnd_rd", d0, 1'b0, {a[31:2], 2'b00}, 3'd2, 32'h0, rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
